// File: rtl/ps2_keyboard_tx_pkg.sv
// Shared constants, state encoding and frame helpers for the PS/2 keyboard
// transmitter and its scan-code FIFO.
package ps2_keyboard_tx_pkg;

    localparam int         FRAME_BITS = 11;
    localparam logic       START_BIT  = 1'b0;
    localparam logic       STOP_BIT   = 1'b1;
    localparam logic [3:0] LAST_IDX   = 4'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_GAP,
        ST_HOLD
    } tx_state_e;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    // Bit idx of the 11-bit frame: start, data LSB first, parity, stop.
    function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
        logic [10:0] frame;
        frame = {STOP_BIT, odd_parity(data), data, START_BIT};
        return frame[idx];
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Scan-code queue: synchronous FIFO with drop-on-full writes and a sticky
// overflow flag. The head byte is visible without popping.
module ps2_tx_fifo
    import ps2_keyboard_tx_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int           DEPTH     = 1 << AW;
    localparam logic [AW:0]  DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] w_ptr_q, w_ptr_d;
    logic [AW-1:0] r_ptr_q, r_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          do_wr, do_rd;

    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign overflow = overflow_q;
    assign rd_data  = mem[r_ptr_q];

    always_comb begin
        do_wr      = wr_en && !full;
        do_rd      = rd_en && !empty;
        w_ptr_d    = w_ptr_q;
        r_ptr_d    = r_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (do_wr) begin
            w_ptr_d = w_ptr_q + 1'b1;
        end
        if (do_rd) begin
            r_ptr_d = r_ptr_q + 1'b1;
        end
        // A write while full is dropped even if the head pops this cycle.
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            w_ptr_q    <= '0;
            r_ptr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            w_ptr_q    <= w_ptr_d;
            r_ptr_q    <= r_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[w_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 transmitter: serialises queued scan codes as 11-bit frames,
// backing off and resending the whole frame if the host inhibits before the stop bit.
module ps2_keyboard_tx
    import ps2_keyboard_tx_pkg::*;
#(
    parameter int CLK_DIV  = 16,
    parameter int AW       = 3,
    parameter int IDLE_GAP = 32
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    input  logic       host_inhibit,
    output logic       full,
    output logic       overflow,
    output logic       busy,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int MAXC = (CLK_DIV > IDLE_GAP) ? CLK_DIV : IDLE_GAP;
    localparam int CW   = $clog2(MAXC);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(IDLE_GAP - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          ps2_clk_q, ps2_clk_d;
    logic          ps2_data_q, ps2_data_d;
    logic          fifo_pop;
    logic          fifo_empty;
    logic [7:0]    fifo_head;

    ps2_tx_fifo #(.AW(AW)) u_fifo (
        .clk      (clk),
        .clrn     (clrn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (fifo_pop),
        .rd_data  (fifo_head),
        .full     (full),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    assign ps2_clk  = ps2_clk_q;
    assign ps2_data = ps2_data_q;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        data_d     = data_q;
        ps2_clk_d  = ps2_clk_q;
        ps2_data_d = ps2_data_q;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d      = '0;
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
                if (!fifo_empty && !host_inhibit) begin
                    data_d     = fifo_head;
                    idx_d      = '0;
                    state_d    = ST_HI;
                    ps2_data_d = frame_bit(fifo_head, 4'd0);
                end
            end
            ST_HI: begin
                if (host_inhibit) begin
                    state_d    = ST_HOLD;
                    cnt_d      = '0;
                    ps2_clk_d  = 1'b1;
                    ps2_data_d = 1'b1;
                end else if (cnt_q == DIV_LAST) begin
                    state_d   = ST_LO;
                    cnt_d     = '0;
                    ps2_clk_d = 1'b0;
                    // Stop-bit falling edge commits the frame: the byte leaves the queue.
                    fifo_pop  = (idx_q == LAST_IDX);
                end
            end
            ST_LO: begin
                if (host_inhibit && idx_q != LAST_IDX) begin
                    state_d    = ST_HOLD;
                    cnt_d      = '0;
                    ps2_clk_d  = 1'b1;
                    ps2_data_d = 1'b1;
                end else if (cnt_q == DIV_LAST) begin
                    cnt_d     = '0;
                    ps2_clk_d = 1'b1;
                    if (idx_q < LAST_IDX) begin
                        idx_d      = idx_q + 4'd1;
                        state_d    = ST_HI;
                        ps2_data_d = frame_bit(data_q, idx_q + 4'd1);
                    end else begin
                        state_d    = ST_GAP;
                        ps2_data_d = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                cnt_d      = '0;
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
                if (!host_inhibit) begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                cnt_d      = '0;
                ps2_clk_d  = 1'b1;
                ps2_data_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Directed bench for ps2_keyboard_tx with a behavioural host receiver that
// samples ps2_data on ps2_clk falling edges.
module tb_ps2_keyboard_tx;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       host_inhibit = 1'b0;
    logic       full, overflow, busy, ps2_clk, ps2_data;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  rx_q[$];
    int          rx_rejects = 0;
    int          rx_falls = 0;
    int          rx_cnt = 0;
    int          frames_seen = 0;
    int          idle_run = 0;
    int          min_gap = 1000000;
    logic [10:0] rx_shift = '0;
    logic [10:0] rx_last_frame = '0;
    logic        rx_prev_clk = 1'b1;
    bit          corrupt_parity = 1'b0;

    ps2_keyboard_tx #(.CLK_DIV(16), .AW(3), .IDLE_GAP(32)) dut (
        .clk          (clk),
        .clrn         (clrn),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .host_inhibit (host_inhibit),
        .full         (full),
        .overflow     (overflow),
        .busy         (busy),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data)
    );

    always #5 clk = ~clk;

    // Host receiver model
    always @(negedge clk) begin
        logic        fall;
        logic [10:0] frame;
        if (!clrn) begin
            rx_cnt      = 0;
            idle_run    = 0;
            rx_prev_clk = 1'b1;
        end else begin
            if (ps2_clk && ps2_data) begin
                idle_run++;
            end else begin
                if (rx_cnt == 0 && idle_run > 0 && frames_seen > 0 && idle_run < min_gap)
                    min_gap = idle_run;
                idle_run = 0;
            end
            fall = rx_prev_clk && !ps2_clk;
            if (fall) rx_falls++;
            if (host_inhibit) begin
                rx_cnt = 0;
            end else if (fall) begin
                rx_shift[rx_cnt] = ps2_data;
                if (rx_cnt == 10) begin
                    frame = rx_shift;
                    if (corrupt_parity) frame[9] = ~frame[9];
                    rx_last_frame = frame;
                    frames_seen++;
                    if (frame[0] == 1'b0 && frame[10] == 1'b1 && (^frame[9:1]) == 1'b1)
                        rx_q.push_back(frame[8:1]);
                    else
                        rx_rejects++;
                    rx_cnt = 0;
                end else begin
                    rx_cnt++;
                end
            end
            rx_prev_clk = ps2_clk;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [4:0] got;
        repeat (3) tick();
        got = {ps2_clk, ps2_data, full, overflow, busy};
        vectors++;
        if (got !== 5'b11000) begin
            miscompares++;
            $display("FAIL reset_state: clk/data/full/ovf/busy got %b expected 11000", got);
        end
        clrn = 1'b1;
        repeat (2) tick();
        $display("reset released, outputs %b", got);
    endtask

    task automatic test_single_frame();
        int cyc = 0, data_at = -1, clk_at = -1, busy_at = -1;
        write_byte(8'h1C);
        for (int i = 0; i < 1000; i++) begin
            tick();
            cyc++;
            if (!ps2_data && data_at < 0) data_at = cyc;
            if (!ps2_clk && clk_at < 0) clk_at = cyc;
            if (!busy) begin
                busy_at = cyc;
                break;
            end
        end
        vectors++;
        if (data_at !== 1) begin
            miscompares++;
            $display("FAIL start_latency: data low after %0d edges expected 1", data_at);
        end
        vectors++;
        if (clk_at !== 17) begin
            miscompares++;
            $display("FAIL first_clk_fall: after %0d edges expected 17", clk_at);
        end
        vectors++;
        if (busy_at !== 385) begin
            miscompares++;
            $display("FAIL busy_drop: after %0d edges expected 385", busy_at);
        end
        vectors++;
        if (rx_last_frame !== 11'h438) begin
            miscompares++;
            $display("FAIL frame_bits_1c: got %h expected 438", rx_last_frame);
        end
        vectors++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h1C) begin
            miscompares++;
            $display("FAIL rx_1c: size %0d head %h expected 1 entry 1c", rx_q.size(),
                     (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
        $display("frame 0x1c: data_low %0d clk_fall %0d busy_low %0d bits %h",
                 data_at, clk_at, busy_at, rx_last_frame);
        rx_q.delete();
    endtask

    task automatic test_parity();
        bit ok;
        int rej0;
        write_byte(8'hF0);
        wait_idle(1000, ok);
        vectors++;
        if (!ok || rx_last_frame !== 11'h7E0) begin
            miscompares++;
            $display("FAIL frame_bits_f0: got %h expected 7e0 (idle %0d)", rx_last_frame, ok);
        end
        vectors++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hF0) begin
            miscompares++;
            $display("FAIL rx_f0: size %0d expected 1 entry f0", rx_q.size());
        end
        $display("frame 0xf0: bits %h parity %b", rx_last_frame, rx_last_frame[9]);
        rx_q.delete();
        rej0 = rx_rejects;
        corrupt_parity = 1'b1;
        write_byte(8'hF0);
        wait_idle(1000, ok);
        corrupt_parity = 1'b0;
        vectors++;
        if (!ok || rx_rejects != rej0 + 1 || rx_q.size() != 0) begin
            miscompares++;
            $display("FAIL parity_reject: rejects %0d accepted %0d expected %0d and 0",
                     rx_rejects - rej0, rx_q.size(), 1);
        end
        $display("corrupted parity frame: rejects %0d", rx_rejects - rej0);
    endtask

    task automatic test_overflow();
        bit ok;
        min_gap = 1000000;
        for (int i = 0; i < 9; i++) write_byte(8'(i));
        vectors++;
        if ({full, overflow} !== 2'b11) begin
            miscompares++;
            $display("FAIL full_overflow: full/ovf got %b expected 11", {full, overflow});
        end
        wait_idle(5000, ok);
        vectors++;
        if (!ok || rx_q.size() != 8) begin
            miscompares++;
            $display("FAIL burst_count: got %0d frames expected 8 (idle %0d)", rx_q.size(), ok);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (i >= rx_q.size() || rx_q[i] !== 8'(i)) begin
                miscompares++;
                $display("FAIL burst_byte%0d: got %h expected %h", i,
                         (i < rx_q.size()) ? rx_q[i] : 8'hxx, 8'(i));
            end
        end
        vectors++;
        if (min_gap < 32) begin
            miscompares++;
            $display("FAIL frame_gap: min %0d cycles expected >= 32", min_gap);
        end
        vectors++;
        if ({full, overflow} !== 2'b01) begin
            miscompares++;
            $display("FAIL sticky_overflow: full/ovf got %b expected 01", {full, overflow});
        end
        $display("burst of 9: %0d frames received, min gap %0d", rx_q.size(), min_gap);
        rx_q.delete();
    endtask

    task automatic test_inhibit_mid();
        bit ok = 1'b0;
        int bad = 0, rej0 = rx_rejects;
        write_byte(8'hA5);
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (rx_cnt == 5) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL reach_idx4: timed out, rx_cnt %0d expected 5", rx_cnt);
        end
        host_inhibit = 1'b1;
        tick();
        vectors++;
        if ({ps2_clk, ps2_data} !== 2'b11) begin
            miscompares++;
            $display("FAIL abort_lines: got %b expected 11", {ps2_clk, ps2_data});
        end
        for (int i = 0; i < 499; i++) begin
            tick();
            if ({ps2_clk, ps2_data} !== 2'b11) bad++;
        end
        vectors++;
        if (bad != 0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_lines: %0d cycles not idle, busy %b expected 0 and 1", bad, busy);
        end
        host_inhibit = 1'b0;
        wait_idle(2000, ok);
        vectors++;
        if (!ok || rx_q.size() != 1 || rx_q[0] !== 8'hA5 || rx_rejects != rej0) begin
            miscompares++;
            $display("FAIL resend_a5: frames %0d rejects %0d expected one a5 frame",
                     rx_q.size(), rx_rejects - rej0);
        end
        $display("inhibit at idx4: resent frames %0d", rx_q.size());
        rx_q.delete();
    endtask

    task automatic test_inhibit_stop();
        bit ok = 1'b0;
        int falls0;
        write_byte(8'h5A);
        write_byte(8'h33);
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (rx_q.size() >= 1) begin
                ok = 1'b1;
                break;
            end
        end
        host_inhibit = 1'b1;
        tick();
        vectors++;
        if (!ok || ps2_clk !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_not_aborted: ps2_clk got %b expected 0 (reached %0d)", ps2_clk, ok);
        end
        falls0 = rx_falls;
        repeat (300) tick();
        vectors++;
        if (rx_falls != falls0 || busy !== 1'b1 || {ps2_clk, ps2_data} !== 2'b11) begin
            miscompares++;
            $display("FAIL inhibit_blocks: falls %0d busy %b lines %b expected 0 1 11",
                     rx_falls - falls0, busy, {ps2_clk, ps2_data});
        end
        host_inhibit = 1'b0;
        wait_idle(2000, ok);
        vectors++;
        if (!ok || rx_q.size() != 2 || rx_q[0] !== 8'h5A || rx_q[1] !== 8'h33) begin
            miscompares++;
            $display("FAIL post_commit: frames %0d expected 5a then 33", rx_q.size());
        end
        $display("inhibit at stop: frames %0d", rx_q.size());
        rx_q.delete();
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        int falls0 = rx_falls;
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_before_reset: got %b expected 1", overflow);
        end
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (rx_falls >= falls0 + 3 && ps2_clk == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        clrn = 1'b0;
        #1;
        vectors++;
        if (!ok || {ps2_clk, ps2_data} !== 2'b11) begin
            miscompares++;
            $display("FAIL async_reset_lines: got %b expected 11 (mid-frame %0d)",
                     {ps2_clk, ps2_data}, ok);
        end
        repeat (2) tick();
        clrn = 1'b1;
        tick();
        vectors++;
        if ({full, overflow, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL post_reset_flags: full/ovf/busy got %b expected 000",
                     {full, overflow, busy});
        end
        falls0 = rx_falls;
        repeat (1000) tick();
        vectors++;
        if (rx_falls != falls0 || rx_q.size() != 0) begin
            miscompares++;
            $display("FAIL no_frames_after_reset: falls %0d frames %0d expected 0 0",
                     rx_falls - falls0, rx_q.size());
        end
        $display("reset mid-frame: falls after release %0d", rx_falls - falls0);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity();
        test_overflow();
        test_inhibit_mid();
        test_inhibit_stop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_tx.md
Name: ps2_keyboard_tx

Overview:
- Device-side PS/2 transmitter; acts as a keyboard emulator that serialises queued scan codes onto ps2_clk/ps2_data.
- Generates frames the host receiver samples on ps2_clk falling edges: start bit, 8 data bits LSB first, odd parity, stop bit.
- Used as a stimulus source for the keyboard path in simulation and on board (loopback into the host receiver).
- Contains a small scan-code FIFO, a bit-timing FSM and host-inhibit handling with retransmit.

Parameters:
- CLK_DIV, 16: clk cycles per ps2_clk half-period; must be ≥4 so a 3-flop synchroniser on the host side sees every edge.
- AW, 3: FIFO address width; depth = 2^AW = 8.
- IDLE_GAP, 32: minimum clk cycles with both lines high between consecutive frames.

Ports:
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- wr_data  in  8  scan code to enqueue
- wr_en  in  1  enqueue strobe, one byte per cycle
- host_inhibit  in  1  host holding the bus (clock-low request); 1 = inhibited
- full  out  1  FIFO holds 2^AW bytes
- overflow  out  1  sticky; set when a write is dropped
- busy  out  1  FSM not in IDLE, or FIFO non-empty
- ps2_clk  out  1  PS/2 clock; idles high
- ps2_data  out  1  PS/2 data; idles high

Behaviour:
- Reset (clrn=0, asynchronous): ps2_clk=1, ps2_data=1, full=0, overflow=0, busy=0, FIFO empty, FSM=IDLE, counters=0. Reset asserted mid-frame forces both lines high at once and discards the frame and all queued bytes.
- FIFO writes:
  - wr_en & !full: byte stored at w_ptr; count increments.
  - wr_en & full: byte dropped, overflow←1. This applies even if a pop happens in the same cycle.
  - overflow clears only on reset.
  - Pointers wrap modulo 2^AW.
- Frame bits, index 0..10: 0=start (0); 1..8=data[0..7]; 9=parity=~^data (odd total over data+parity); 10=stop (1).
- FSM states:
  - IDLE: ps2_clk=1, ps2_data=1. If FIFO non-empty and !host_inhibit: load head byte (no pop), idx←0, go to HI, drive ps2_data=bit0.
  - HI: ps2_clk=1, ps2_data=bit[idx]. Lasts CLK_DIV cycles, then go to LO (ps2_clk←0).
  - LO: ps2_clk=0, ps2_data held. Lasts CLK_DIV cycles. Then:
    - idx<10: idx++, go to HI with the new bit.
    - idx=10: ps2_clk←1, ps2_data←1, go to GAP.
  - GAP: both lines high for IDLE_GAP cycles, then go to IDLE. Back-to-back frames are therefore separated by ≥IDLE_GAP cycles.
  - HOLD: both lines high while host_inhibit=1. On release, go to GAP.
- Pop: FIFO head is popped on the cycle the FSM enters LO with idx=10 (stop-bit falling edge). The frame is committed from that point on.
- Inhibit:
  - Sampled every cycle.
  - In HI/LO before commit: abort next cycle (lines high), go to HOLD; the byte stays queued and the whole frame is resent after HOLD→GAP.
  - After commit, inhibit is ignored until GAP ends; it then blocks IDLE from starting a new frame.
- Latency: wr_en at edge t into an empty idle block gives ps2_data=0 after edge t+1. The first ps2_clk fall follows CLK_DIV cycles later.
- Frame duration: 22*CLK_DIV cycles, plus IDLE_GAP.
- All outputs are registered, with no combinational path from inputs to ps2_clk/ps2_data.

Decomposition:
- Shared package/header holds:
  - FRAME_BITS=11, START_BIT=0, STOP_BIT=1
  - Parity function (odd)
  - FSM state encoding: IDLE, HI, LO, GAP, HOLD
- One sub-module, ps2_tx_fifo: synchronous FIFO with AW-bit pointers, count, full/empty, and a drop-on-full write port.
- FSM, divider and bit counter stay in ps2_keyboard_tx.

Test Plan:
- Write 0x1C, loop back into the host receiver (CLK_DIV=16) -> serial 0,0,0,1,1,1,0,0,0,0,1; receiver ready=1, data=0x1C; busy drops after 352+32 cycles.
- Write 0xF0 -> parity bit=1; receiver accepts 0xF0. Force-corrupt the parity in the bench -> receiver rejects the frame.
- 9 writes on consecutive cycles while idle -> first 8 accepted, full=1, overflow=1; receiver gets 0x00..0x07 in order, each frame gap ≥32 cycles; 9th byte never appears.
- Assert host_inhibit during LO of idx=4 for 500 cycles -> lines high the next cycle and through the hold; after release + gap, the same byte is resent in full; receiver logs it exactly once.
- Assert host_inhibit during LO of idx=10 -> frame completes and the byte is popped; next frame does not start until inhibit clears.
- Pulse clrn low mid-frame with 3 bytes queued -> ps2_clk=ps2_data=1 asynchronously; after release full=0, busy=0, overflow=0, no further frames.
